// File: rtl/braun_mul_seq.sv
// braun_mul_seq -- sequential (4*NIB)x(4*NIB) unsigned multiplier.
//
// Purpose:
//   Computes a*b by time-sharing one combinational 4x4 Braun array.
//   Each cycle in MUL, one nibble pair (a[i], b[j]) goes through the array.
//   The partial product is shifted by 4*(i+j) and added into a 2W-bit accumulator.
//
// Ports:
//   clk          in   1   clock; all state updates on the rising edge
//   rst          in   1   synchronous, active-high reset; aborts any operation
//   start_valid  in   1   a/b are valid
//   start_ready  out  1   block accepts operands (IDLE only, low during rst)
//   a, b         in   W   operands, latched on the accept edge
//   busy         out  1   high in MUL or DONE
//   done_valid   out  1   p holds a completed product
//   done_ready   in   1   consumer takes p
//   p            out  2W  registered product; held until the next result
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The valid side does not wait on ready. Ready is decoded from the
// registered state only, with the exception that start_ready is also gated by rst.

module Braun_Multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // Braun array: carry-save rows of full adders, then a ripple row.
  // After row i, s[j] has weight 2^(i+j) and c[j] has weight 2^(i+j+1).
  logic [3:0] s, c, ns, nc, sh;
  logic       cy;

  always_comb begin
    p  = '0;
    ns = '0;
    nc = '0;
    cy = 1'b0;
    for (int j = 0; j < 4; j++) s[j] = a[j] & b[0];
    c = '0;
    for (int i = 1; i < 4; i++) begin
      p[i-1] = s[0];
      sh     = s >> 1;
      for (int j = 0; j < 4; j++)
        {nc[j], ns[j]} = 2'(a[j] & b[i]) + 2'(sh[j]) + 2'(c[j]);
      s = ns;
      c = nc;
    end
    p[3] = s[0];
    sh   = s >> 1;
    // Final carry-propagate row; the top column has no sum input.
    for (int k = 0; k < 3; k++)
      {cy, p[4+k]} = 2'(sh[k]) + 2'(c[k]) + 2'(cy);
    p[7] = c[3] ^ cy;
  end
endmodule

module braun_mul_seq #(
  parameter int NIB = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  output logic               busy,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [8*NIB-1:0]   p
);
  localparam int W  = 4 * NIB;
  localparam int PW = 2 * W;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, p_q, p_d;
  logic [CW-1:0]   i_q, i_d, j_q, j_d;

  logic [3:0]      nib_a, nib_b;
  logic [7:0]      pp;
  logic [PW-1:0]   term;
  logic            last;

  assign nib_a = a_q[4*i_q +: 4];
  assign nib_b = b_q[4*j_q +: 4];

  Braun_Multiplier u_array (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  always_comb begin
    term = PW'(pp) << (4 * (int'(i_q) + int'(j_q)));
  end

  assign last = (i_q == CW'(NIB - 1)) && (j_q == CW'(NIB - 1));

  // State register (plus datapath registers).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + term;
        if (last) begin
          // The last term goes straight into p so the result is visible on DONE entry.
          p_d     = acc_q + term;
          state_d = S_DONE;
        end else if (j_q == CW'(NIB - 1)) begin
          j_d = '0;
          i_d = i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    start_ready = (state_q == S_IDLE) && !rst;
    busy        = (state_q == S_MUL) || (state_q == S_DONE);
    done_valid  = (state_q == S_DONE);
    p           = p_q;
  end
endmodule
